// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline stall/flush
//               sequencer: stall-source priority encoding, default exception
//               vector and divider state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic [31:0] c_EXC_VECTOR_DEFAULT = 32'hBFC00380;
    localparam int unsigned c_DIV_CYCLES_DEFAULT = 32;
    localparam int unsigned c_DIV_CNT_W          = 8;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Higher encoding = higher priority.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_FWD  = 3'd1,
        SRC_DIV  = 3'd2,
        SRC_MEM  = 3'd3,
        SRC_EXC  = 3'd4
    } stall_src_t;

    // Picks the single stall source that shapes the pipeline controls.
    function automatic stall_src_t stall_src_sel(
        input logic exc,
        input logic mem_wait,
        input logic div_stall,
        input logic fwd
    );
        if (exc)       return SRC_EXC;
        if (mem_wait)  return SRC_MEM;
        if (div_stall) return SRC_DIV;
        if (fwd)       return SRC_FWD;
        return SRC_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Hazard inputs and stage controls between the pipeline and
//               the stall/flush sequencer. Performance counter signals exist
//               only when PIPE_CTRL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;

    logic        stall_fwd;
    logic        ex_div;
    logic        mm_mem_req;
    logic        mm_mem_ack;
    logic        mm_exc;

    logic        en_pc;
    logic        en_id;
    logic        en_ex;
    logic        en_mm;
    logic        en_wb;
    logic        flush_id;
    logic        flush_ex;
    logic        flush_mm;
    logic        flush_wb;
    logic        div_busy;
    logic        div_done;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;
`endif

    // Controller side.
    modport master (
`ifdef PIPE_CTRL_PERF_EN
        output perf_stall_cycles, perf_flush_events,
`endif
        input  stall_fwd, ex_div, mm_mem_req, mm_mem_ack, mm_exc,
        output en_pc, en_id, en_ex, en_mm, en_wb,
        output flush_id, flush_ex, flush_mm, flush_wb,
        output div_busy, div_done, pc_redirect, redirect_addr
    );

    // Pipeline side.
    modport slave (
`ifdef PIPE_CTRL_PERF_EN
        input  perf_stall_cycles, perf_flush_events,
`endif
        output stall_fwd, ex_div, mm_mem_req, mm_mem_ack, mm_exc,
        input  en_pc, en_id, en_ex, en_mm, en_wb,
        input  flush_id, flush_ex, flush_mm, flush_wb,
        input  div_busy, div_done, pc_redirect, redirect_addr
    );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_div_seq.sv
// ============================================================================
// Module      : pipe_ctrl_div_seq
// Description : Divider sequencer. Counts the EX-stage divide, stalls the
//               front of the pipe until the result is ready and holds DONE
//               until EX actually advances so a divide never restarts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = c_DIV_CYCLES_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_ex_div,
    input  wire logic i_mm_exc,
    input  wire logic i_ex_adv,
    output logic      o_div_stall,
    output logic      o_div_busy,
    output logic      o_div_done
);

    localparam logic [c_DIV_CNT_W-1:0] c_CNT_LOAD = c_DIV_CNT_W'(DIV_CYCLES - 1);

    div_state_t               r_state;
    div_state_t               w_state_nxt;
    logic [c_DIV_CNT_W-1:0]   r_cnt;
    logic [c_DIV_CNT_W-1:0]   w_cnt_nxt;

    // Outputs decode from the registered state only, so the EX enable fed
    // back through i_ex_adv never loops into the stall it depends on.
    assign o_div_busy  = (r_state == DIV_BUSY);
    assign o_div_done  = (r_state == DIV_DONE);
    assign o_div_stall = o_div_busy | ((r_state == DIV_IDLE) & i_ex_div & ~i_mm_exc);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: the start cycle counts as the first stall cycle, so BUSY
    // lasts DIV_CYCLES-1 cycles; an exception aborts from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            DIV_IDLE: begin
                if (i_ex_div) begin
                    w_state_nxt = DIV_BUSY;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            DIV_BUSY: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_DIV_CNT_W'(1)) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (i_ex_adv) begin
                    w_state_nxt = DIV_IDLE;
                end
            end
            default: begin
                w_state_nxt = DIV_IDLE;
            end
        endcase
        if (i_mm_exc) begin
            w_state_nxt = DIV_IDLE;
            w_cnt_nxt   = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Merges exception, memory wait, divider and forwarding stalls
//               by priority into stage enables, bubble flushes and the PC
//               redirect. Optional counters: PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = c_DIV_CYCLES_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = c_EXC_VECTOR_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_ctrl_if.master bus
);

    logic       w_mem_wait;
    logic       w_div_stall;
    logic       w_div_busy;
    logic       w_div_done;
    stall_src_t w_src;
    logic [4:0] w_en;       // {pc, id, ex, mm, wb}
    logic [3:0] w_flush;    // {id, ex, mm, wb}
    logic       w_redirect;

    // An ack in the same cycle as the request completes without stalling.
    assign w_mem_wait = bus.mm_mem_req & ~bus.mm_mem_ack;
    assign w_src      = stall_src_sel(bus.mm_exc, w_mem_wait, w_div_stall, bus.stall_fwd);

    pipe_ctrl_div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk         (clk),
        .rst         (rst),
        .i_ex_div    (bus.ex_div),
        .i_mm_exc    (bus.mm_exc),
        .i_ex_adv    (w_en[2]),
        .o_div_stall (w_div_stall),
        .o_div_busy  (w_div_busy),
        .o_div_done  (w_div_done)
    );

    // A stall from stage k holds stages up to k and bubbles stage k+1;
    // reset holds everything and fills every stage with bubbles.
    always_comb begin
        w_en       = 5'b11111;
        w_flush    = 4'b0000;
        w_redirect = 1'b0;
        if (rst) begin
            w_en    = 5'b00000;
            w_flush = 4'b1111;
        end else begin
            case (w_src)
                SRC_EXC: begin
                    w_flush    = 4'b1111;
                    w_redirect = 1'b1;
                end
                SRC_MEM: begin
                    w_en    = 5'b00001;
                    w_flush = 4'b0001;
                end
                SRC_DIV: begin
                    w_en    = 5'b00011;
                    w_flush = 4'b0010;
                end
                SRC_FWD: begin
                    w_en    = 5'b00111;
                    w_flush = 4'b0100;
                end
                default: begin
                    w_en    = 5'b11111;
                end
            endcase
        end
    end

    assign bus.en_pc         = w_en[4];
    assign bus.en_id         = w_en[3];
    assign bus.en_ex         = w_en[2];
    assign bus.en_mm         = w_en[1];
    assign bus.en_wb         = w_en[0];
    assign bus.flush_id      = w_flush[3];
    assign bus.flush_ex      = w_flush[2];
    assign bus.flush_mm      = w_flush[1];
    assign bus.flush_wb      = w_flush[0];
    assign bus.div_busy      = w_div_busy;
    assign bus.div_done      = w_div_done;
    assign bus.pc_redirect   = w_redirect;
    assign bus.redirect_addr = EXC_VECTOR;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_flush_events;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall_cycles <= '0;
            r_perf_flush_events <= '0;
        end else begin
            if (!w_en[4]) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
            if (w_redirect) begin
                r_perf_flush_events <= r_perf_flush_events + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cycles = r_perf_stall_cycles;
    assign bus.perf_flush_events = r_perf_flush_events;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl with a cycle-level
//               behavioural model of the stall priorities and divide timing.
//               Counter checks added when PIPE_CTRL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int unsigned DIV_CYCLES = 4;
    localparam logic [31:0] EXC_VEC    = 32'hBFC00380;
    // Vector order: {en_pc,en_id,en_ex,en_mm,en_wb, flush_id,ex,mm,wb, busy,done,redirect}
    localparam logic [11:0] RST_VEC    = 12'b00000_1111_000;
    localparam logic [11:0] RUN_VEC    = 12'b11111_0000_000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .DIV_CYCLES (DIV_CYCLES),
        .EXC_VECTOR (EXC_VEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a divide is "on" from the edge after its start cycle; m_elapsed
    // counts cycles since start. Result is ready once DIV_CYCLES have passed.
    bit m_on      = 1'b0;
    int m_elapsed = 0;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;
`endif

    function automatic logic [11:0] obs();
        return {bus.en_pc, bus.en_id, bus.en_ex, bus.en_mm, bus.en_wb,
                bus.flush_id, bus.flush_ex, bus.flush_mm, bus.flush_wb,
                bus.div_busy, bus.div_done, bus.pc_redirect};
    endfunction

    function automatic logic [11:0] model_exp();
        logic mw, start, busy, done;
        if (rst) return RST_VEC;
        mw    = bus.mm_mem_req & ~bus.mm_mem_ack;
        start = !m_on && bus.ex_div && !bus.mm_exc;
        busy  = m_on && (m_elapsed < int'(DIV_CYCLES));
        done  = m_on && (m_elapsed >= int'(DIV_CYCLES));
        if (bus.mm_exc)     return {5'b11111, 4'b1111, busy, done, 1'b1};
        if (mw)             return {5'b00001, 4'b0001, busy, done, 1'b0};
        if (start || busy)  return {5'b00011, 4'b0010, busy, done, 1'b0};
        if (bus.stall_fwd)  return {5'b00111, 4'b0100, busy, done, 1'b0};
        return {5'b11111, 4'b0000, busy, done, 1'b0};
    endfunction

    task automatic drive(input logic s, input logic d, input logic rq, input logic ak, input logic ex);
        bus.stall_fwd  = s;
        bus.ex_div     = d;
        bus.mm_mem_req = rq;
        bus.mm_mem_ack = ak;
        bus.mm_exc     = ex;
        #3;
    endtask

    // Advance the model and the clock together; ends 1 time unit past the edge.
    task automatic tick();
        logic [11:0] e;
        bit          n_on;
        int          n_el;
        e    = model_exp();
        n_on = m_on;
        n_el = m_elapsed;
        if (rst || bus.mm_exc) begin
            n_on = 1'b0;
        end else if (!m_on) begin
            if (bus.ex_div) begin
                n_on = 1'b1;
                n_el = 1;
            end
        end else if (m_elapsed < int'(DIV_CYCLES)) begin
            n_el = m_elapsed + 1;
        end else if (e[9]) begin
            n_on = 1'b0;
        end
`ifdef PIPE_CTRL_PERF_EN
        if (rst) begin
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else begin
            if (!e[11]) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e[0])   m_flush_cnt = m_flush_cnt + 32'd1;
        end
`endif
        @(posedge clk);
        m_on      = n_on;
        m_elapsed = n_el;
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] g;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        #3;
        g = obs();
        n_checks++;
        if (g !== RST_VEC) $display("FAIL reset_outputs: got %b expected %b", g, RST_VEC);
        else n_pass++;
        n_checks++;
        if (bus.redirect_addr !== EXC_VEC) $display("FAIL reset_redirect_addr: got %h expected %h", bus.redirect_addr, EXC_VEC);
        else n_pass++;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        g = obs();
        n_checks++;
        if (g !== RUN_VEC) $display("FAIL reset_release: got %b expected %b", g, RUN_VEC);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall_fwd();
        logic [11:0] g, e;
        drive(1, 0, 0, 0, 0);
        g = obs();
        e = 12'b00111_0100_000;
        n_checks++;
        if (g !== e) $display("FAIL stall_fwd_active: got %b expected %b", g, e);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        g = obs();
        n_checks++;
        if (g !== RUN_VEC) $display("FAIL stall_fwd_release: got %b expected %b", g, RUN_VEC);
        else n_pass++;
        tick();
    endtask

    task automatic test_div();
        logic [11:0] g, e;
        int stalls   = 0;
        int done_cyc = 0;
        for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
            drive(0, 1, 0, 0, 0);
            g = obs();
            e = model_exp();
            n_checks++;
            if (g !== e) $display("FAIL div_model cyc %0d: got %b expected %b", c, g, e);
            else n_pass++;
            if (!bus.en_ex) stalls++;
            if (bus.div_done) begin
                done_cyc = c;
                n_checks++;
                if (bus.en_ex !== 1'b1) $display("FAIL div_done_en_ex: got %b expected 1", bus.en_ex);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (stalls != int'(DIV_CYCLES)) $display("FAIL div_stall_cycles: got %0d expected %0d", stalls, DIV_CYCLES);
        else n_pass++;
        n_checks++;
        if (done_cyc != int'(DIV_CYCLES) + 1) $display("FAIL div_done_cycle: got %0d expected %0d", done_cyc, DIV_CYCLES + 1);
        else n_pass++;
        drive(0, 0, 0, 0, 0);
        g = obs();
        n_checks++;
        if (g !== RUN_VEC) $display("FAIL div_back_idle: got %b expected %b", g, RUN_VEC);
        else n_pass++;
        tick();
    endtask

    task automatic test_div_mem_wait();
        logic [11:0] g, e;
        for (int c = 1; c <= 7; c++) begin
            drive(0, 1, 1, (c == 7), 0);
            g = obs();
            e = model_exp();
            n_checks++;
            if (g !== e) $display("FAIL divmem_model cyc %0d: got %b expected %b", c, g, e);
            else n_pass++;
            if (c >= 5) begin
                n_checks++;
                if ({bus.div_busy, bus.div_done} !== 2'b01)
                    $display("FAIL divmem_hold_done cyc %0d: got %b expected 01", c, {bus.div_busy, bus.div_done});
                else n_pass++;
            end
            if (c <= 6) begin
                n_checks++;
                if ({bus.flush_wb, bus.en_mm, bus.en_ex} !== 3'b100)
                    $display("FAIL divmem_wait cyc %0d: got %b expected 100", c, {bus.flush_wb, bus.en_mm, bus.en_ex});
                else n_pass++;
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        g = obs();
        n_checks++;
        if (g !== RUN_VEC) $display("FAIL divmem_idle: got %b expected %b", g, RUN_VEC);
        else n_pass++;
        tick();
    endtask

    task automatic test_exc_mid_div();
        logic [11:0] g, e;
        drive(0, 1, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 1);
        g = obs();
        e = 12'b11111_1111_101;
        n_checks++;
        if (g !== e) $display("FAIL exc_outputs: got %b expected %b", g, e);
        else n_pass++;
        n_checks++;
        if (bus.redirect_addr !== EXC_VEC) $display("FAIL exc_redirect_addr: got %h expected %h", bus.redirect_addr, EXC_VEC);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        g = obs();
        n_checks++;
        if (g !== RUN_VEC) $display("FAIL exc_abort_idle: got %b expected %b", g, RUN_VEC);
        else n_pass++;
        tick();
    endtask

    task automatic test_mem_ack_same();
        logic [11:0] g, e;
        drive(0, 0, 1, 1, 0);
        g = obs();
        n_checks++;
        if (g !== RUN_VEC) $display("FAIL ack_same_cycle: got %b expected %b", g, RUN_VEC);
        else n_pass++;
        tick();
        drive(0, 0, 1, 1, 1);
        g = obs();
        e = 12'b11111_1111_001;
        n_checks++;
        if (g !== e) $display("FAIL ack_with_exc: got %b expected %b", g, e);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [11:0] g, e;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(63) == 0);
            drive(($urandom_range(3) == 0), ($urandom_range(2) == 0), ($urandom_range(9) < 3),
                  ($urandom_range(1) == 0), ($urandom_range(19) == 0));
            g = obs();
            e = model_exp();
            n_checks++;
            if (g !== e) $display("FAIL random_model cyc %0d: got %b expected %b", c, g, e);
            else n_pass++;
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        #3;
        n_checks++;
        if (bus.perf_stall_cycles !== m_stall_cnt)
            $display("FAIL perf_stall_cycles: got %0d expected %0d", bus.perf_stall_cycles, m_stall_cnt);
        else n_pass++;
        n_checks++;
        if (bus.perf_flush_events !== m_flush_cnt)
            $display("FAIL perf_flush_events: got %0d expected %0d", bus.perf_flush_events, m_flush_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_stall_fwd();
        test_div();
        test_div_mem_wait();
        test_exc_mid_div();
        test_mem_ack_same();
        test_random();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
